array_frame_loader: RTL and testbench

- Upstream feeder for the min/max array search tree.
- Collects a serial sample stream (valid/ready, with last marker) into a DEPTH-entry register array and presents it on the search block's array input.
- Holds the array stable for the search pipeline latency and emits a strobe in the cycle the search result is valid for that frame.
- Handles short frames (pads the unfilled entries) and long frames (discards the excess samples).

---
 rtl/array_frame_loader_if.sv | 35 +++
 rtl/array_frame_loader.sv | 129 ++++++++++++
 tb/tb_array_frame_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/array_frame_loader_if.sv
// Sample-stream and frame-presentation bundle between the feeder source,
// the frame loader, and the downstream min/max search tree.
interface array_frame_loader_if #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 8,
    parameter int LWIDTH = $clog2(DEPTH + 1)
);
    // Handshake: a beat transfers on a rising clk edge where s_valid & s_ready
    // are both high; s_data/s_last must be stable while s_valid is high, and
    // s_ready may drop without a transfer (loader busy holding a frame).
    logic                         s_valid;
    logic                         s_ready;
    logic [DWIDTH-1:0]            s_data;
    logic                         s_last;

    logic [DEPTH-1:0][DWIDTH-1:0] array;
    logic                         load_done;
    logic                         result_strobe;
    logic [LWIDTH-1:0]            frame_len;
    logic                         short_frame;
    logic                         overrun;
    logic                         busy;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, array, load_done, result_strobe, frame_len,
               short_frame, overrun, busy
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, array, load_done, result_strobe, frame_len,
               short_frame, overrun, busy
    );
endinterface

// File: rtl/array_frame_loader.sv
// Collects a serial sample stream into a DEPTH-entry array, holds it stable for
// the search pipeline latency, and strobes when the search result is valid.
module array_frame_loader #(
    parameter int                DWIDTH      = 8,
    parameter int                DEPTH       = 8,
    parameter int                HOLD_CYCLES = 3,
    parameter logic [DWIDTH-1:0] PAD_VALUE   = {DWIDTH{1'b1}},
    parameter int                LWIDTH      = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    array_frame_loader_if.slave  bus,
    output logic [1:0]           o_dbg_state
);
    localparam int IWIDTH = $clog2(DEPTH);
    localparam int HWIDTH = 4;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                       r_state;
    logic [IWIDTH-1:0]            r_idx;
    logic [HWIDTH-1:0]            r_hold_cnt;
    logic                         r_drain_pend;
    logic [DEPTH-1:0][DWIDTH-1:0] r_array;
    logic [LWIDTH-1:0]            r_frame_len;
    logic                         r_short;
    logic                         r_overrun;
    logic                         r_load_done;
    logic                         r_result_strobe;
    logic                         r_busy;

    logic                         w_at_end;
    logic                         w_strobe_at_entry;

    assign w_at_end          = (r_idx == IWIDTH'(DEPTH - 1));
    assign w_strobe_at_entry = (HOLD_CYCLES == 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= FILL;
            r_idx           <= '0;
            r_hold_cnt      <= '0;
            r_drain_pend    <= 1'b0;
            r_array         <= '0;
            r_frame_len     <= '0;
            r_short         <= 1'b0;
            r_overrun       <= 1'b0;
            r_load_done     <= 1'b0;
            r_result_strobe <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_load_done     <= 1'b0;
            r_result_strobe <= 1'b0;
            case (r_state)
                FILL: begin
                    if (bus.s_valid) begin
                        r_array[r_idx] <= bus.s_data;
                        if (w_at_end || bus.s_last) begin
                            // Frame complete: flags and length change on the
                            // same edge the last entry lands.
                            if (w_at_end) begin
                                r_frame_len  <= LWIDTH'(DEPTH);
                                r_short      <= 1'b0;
                                r_overrun    <= ~bus.s_last;
                                r_drain_pend <= ~bus.s_last;
                            end else begin
                                for (int i = 0; i < DEPTH; i++) begin
                                    if (i > int'(r_idx))
                                        r_array[i] <= PAD_VALUE;
                                end
                                r_frame_len  <= LWIDTH'(r_idx) + LWIDTH'(1);
                                r_short      <= 1'b1;
                                r_overrun    <= 1'b0;
                                r_drain_pend <= 1'b0;
                            end
                            r_state         <= HOLD;
                            r_idx           <= '0;
                            r_hold_cnt      <= '0;
                            r_load_done     <= 1'b1;
                            r_result_strobe <= w_strobe_at_entry;
                            r_busy          <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IWIDTH'(1);
                        end
                    end
                end

                HOLD: begin
                    if (r_hold_cnt == HWIDTH'(HOLD_CYCLES)) begin
                        r_state <= r_drain_pend ? DRAIN : FILL;
                        r_busy  <= r_drain_pend;
                    end else begin
                        // Registered strobe: raise it on the edge that makes
                        // the count reach HOLD_CYCLES.
                        r_hold_cnt      <= r_hold_cnt + HWIDTH'(1);
                        r_result_strobe <= ((r_hold_cnt + HWIDTH'(1)) == HWIDTH'(HOLD_CYCLES));
                    end
                end

                DRAIN: begin
                    if (bus.s_valid && bus.s_last) begin
                        r_state      <= FILL;
                        r_drain_pend <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                end

                default: begin
                    r_state <= FILL;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready       = (r_state != HOLD);
    assign bus.array         = r_array;
    assign bus.load_done     = r_load_done;
    assign bus.result_strobe = r_result_strobe;
    assign bus.frame_len     = r_frame_len;
    assign bus.short_frame   = r_short;
    assign bus.overrun       = r_overrun;
    assign bus.busy          = r_busy;
    assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_array_frame_loader.sv
// Self-checking bench: frames go into a scoreboard queue when driven and are
// compared when load_done fires; strobe latency and HOLD back-pressure checked live.
module tb_array_frame_loader;
    localparam int FW = 64 + 4 + 2;

    logic clk;
    logic rst;
    logic [1:0] dbg3;
    logic [1:0] dbg0;

    array_frame_loader_if #(.DWIDTH(8), .DEPTH(8)) bus3 ();
    array_frame_loader_if #(.DWIDTH(8), .DEPTH(8)) bus0 ();

    array_frame_loader #(.DWIDTH(8), .DEPTH(8), .HOLD_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3), .o_dbg_state(dbg3)
    );
    array_frame_loader #(.DWIDTH(8), .DEPTH(8), .HOLD_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .o_dbg_state(dbg0)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [FW-1:0] exp_q3[$];
    logic [FW-1:0] exp_q0[$];
    int            ld_cyc3[$];
    logic [7:0]    smp[32];

    bit pend[2];
    int since[2];
    int ld_cnt[2];
    int rs_cnt[2];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference frame: pad short frames with FF, truncate long ones at 8.
    function automatic logic [FW-1:0] model(input int n);
        logic [7:0][7:0] arr;
        logic [3:0]      len;
        for (int i = 0; i < 8; i++) arr[i] = (i < n) ? smp[i] : 8'hFF;
        len = (n > 8) ? 4'd8 : 4'(n);
        return {arr, len, (n < 8), (n > 8)};
    endfunction

    // driver tasks
    task automatic set_beat(input bit which, input logic v, input logic [7:0] d, input logic last);
        if (which) begin
            bus0.s_valid = v; bus0.s_data = d; bus0.s_last = last;
        end else begin
            bus3.s_valid = v; bus3.s_data = d; bus3.s_last = last;
        end
    endtask

    task automatic drive_beat(input bit which, input logic [7:0] d, input logic last);
        logic rdy;
        set_beat(which, 1'b1, d, last);
        for (int b = 0; b < 60; b++) begin
            @(negedge clk);
            rdy = which ? bus0.s_ready : bus3.s_ready;
            if (rdy) break;
        end
        if (!rdy) chk("beat_wait_ready", {63'd0, rdy}, 64'd1);
        @(posedge clk);
        #1;
        set_beat(which, 1'b0, d, 1'b0);
    endtask

    task automatic send_frame(input bit which, input int n, input bit gap, input bit push);
        if (push) begin
            if (which) exp_q0.push_back(model(n));
            else       exp_q3.push_back(model(n));
        end
        for (int i = 0; i < n; i++) begin
            drive_beat(which, smp[i], (i == n - 1));
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle(input bit which);
        logic bsy;
        bsy = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            bsy = which ? bus0.busy : bus3.busy;
            if (!bsy && !pend[which]) break;
        end
        if (bsy) chk("idle_wait", {63'd0, bsy}, 64'd0);
        @(posedge clk);
        #1;
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        for (int w = 0; w < 2; w++) begin
            logic            ld, rs, rdy, sh, ov;
            logic [63:0]     arr;
            logic [3:0]      len;
            logic [FW-1:0]   e;
            int              hold;
            if (w == 1) begin
                ld = bus0.load_done; rs = bus0.result_strobe; rdy = bus0.s_ready;
                arr = bus0.array; len = bus0.frame_len; sh = bus0.short_frame; ov = bus0.overrun;
                hold = 0;
            end else begin
                ld = bus3.load_done; rs = bus3.result_strobe; rdy = bus3.s_ready;
                arr = bus3.array; len = bus3.frame_len; sh = bus3.short_frame; ov = bus3.overrun;
                hold = 3;
            end
            if (pend[w]) since[w]++;
            if (ld) begin
                if ((w == 1) ? (exp_q0.size() == 0) : (exp_q3.size() == 0)) begin
                    chk("unexp_load", {63'd0, ld}, 64'd0);
                end else begin
                    if (w == 1) e = exp_q0.pop_front();
                    else        e = exp_q3.pop_front();
                    chk("array",       arr,            e[69:6]);
                    chk("frame_len",   {60'd0, len},   {60'd0, e[5:2]});
                    chk("short_frame", {63'd0, sh},    {63'd0, e[1]});
                    chk("overrun",     {63'd0, ov},    {63'd0, e[0]});
                end
                pend[w] = 1'b1;
                since[w] = 0;
                ld_cnt[w]++;
                if (w == 0) ld_cyc3.push_back(cyc);
            end
            if (pend[w]) chk("hold_ready", {63'd0, rdy}, 64'd0);
            if (rs) begin
                if (!pend[w]) begin
                    chk("unexp_strobe", {63'd0, rs}, 64'd0);
                end else begin
                    chk("strobe_lat", 64'(since[w]), 64'(hold));
                    pend[w] = 1'b0;
                    rs_cnt[w]++;
                end
            end
        end
    end

    initial begin
        logic [FW-1:0] exp_frame;
        int            n0;
        int            r0;
        set_beat(1'b0, 1'b0, 8'd0, 1'b0);
        set_beat(1'b1, 1'b0, 8'd0, 1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_array",  bus3.array, 64'd0);
        chk("rst_len",    {60'd0, bus3.frame_len}, 64'd0);
        chk("rst_flags",  {60'd0, bus3.short_frame, bus3.overrun, bus3.load_done, bus3.result_strobe}, 64'd0);
        chk("rst_busy",   {63'd0, bus3.busy}, 64'd0);
        chk("rst_ready",  {63'd0, bus3.s_ready}, 64'd1);
        chk("rst_state3", {62'd0, dbg3}, 64'd0);
        chk("rst_state0", {62'd0, dbg0}, 64'd0);
        @(posedge clk);
        #1;

        // full frame
        smp[0] = 8'd5; smp[1] = 8'd3; smp[2] = 8'd9; smp[3] = 8'd1;
        smp[4] = 8'd7; smp[5] = 8'd2; smp[6] = 8'd8; smp[7] = 8'd6;
        send_frame(1'b0, 8, 1'b0, 1'b1);
        @(negedge clk);
        chk("ld_latency", {63'd0, bus3.load_done}, 64'd1);
        wait_idle(1'b0);

        // short frame
        smp[0] = 8'd4; smp[1] = 8'd2; smp[2] = 8'd6;
        send_frame(1'b0, 3, 1'b0, 1'b1);
        wait_idle(1'b0);

        // single-sample frame
        smp[0] = 8'($urandom_range(0, 254));
        send_frame(1'b0, 1, 1'b0, 1'b1);
        wait_idle(1'b0);

        // overrun: 11 beats, 9..11 drained
        for (int i = 0; i < 11; i++) smp[i] = 8'(i + 1);
        exp_frame = model(11);
        send_frame(1'b0, 11, 1'b0, 1'b1);
        wait_idle(1'b0);
        chk("drain_keeps_array", bus3.array, exp_frame[69:6]);
        for (int i = 0; i < 8; i++) smp[i] = 8'($urandom_range(0, 255));
        send_frame(1'b0, 8, 1'b0, 1'b1);
        wait_idle(1'b0);

        // reset mid-frame
        n0 = ld_cnt[0];
        r0 = rs_cnt[0];
        for (int i = 0; i < 8; i++) smp[i] = 8'($urandom_range(0, 255));
        send_frame(1'b0, 4, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_array", bus3.array, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {63'd0, bus3.s_ready}, 64'd1);
        chk("midrst_array2", bus3.array, 64'd0);
        chk("midrst_len", {60'd0, bus3.frame_len}, 64'd0);
        repeat (6) @(negedge clk);
        chk("midrst_no_ld", 64'(ld_cnt[0] - n0), 64'd0);
        chk("midrst_no_rs", 64'(rs_cnt[0] - r0), 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) smp[i] = 8'($urandom_range(0, 255));
        send_frame(1'b0, 8, 1'b0, 1'b1);
        wait_idle(1'b0);

        // back-to-back frames
        n0 = ld_cyc3.size();
        r0 = rs_cnt[0];
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) smp[i] = 8'($urandom_range(0, 255));
            send_frame(1'b0, 8, 1'b0, 1'b1);
        end
        wait_idle(1'b0);
        chk("b2b_ld_count", 64'(ld_cyc3.size() - n0), 64'd3);
        chk("b2b_rs_count", 64'(rs_cnt[0] - r0), 64'd3);
        if (ld_cyc3.size() >= n0 + 3) begin
            chk("b2b_gap1", 64'(ld_cyc3[n0 + 1] - ld_cyc3[n0]), 64'd12);
            chk("b2b_gap2", 64'(ld_cyc3[n0 + 2] - ld_cyc3[n0 + 1]), 64'd12);
        end

        // HOLD_CYCLES=0 with bubbles
        for (int i = 0; i < 8; i++) smp[i] = 8'($urandom_range(0, 255));
        send_frame(1'b1, 8, 1'b1, 1'b1);
        wait_idle(1'b1);
        for (int i = 0; i < 5; i++) smp[i] = 8'($urandom_range(0, 255));
        send_frame(1'b1, 5, 1'b1, 1'b1);
        wait_idle(1'b1);
        chk("h0_ld_count", 64'(ld_cnt[1]), 64'd2);
        chk("h0_rs_count", 64'(rs_cnt[1]), 64'd2);

        repeat (4) @(negedge clk);
        chk("q3_empty", 64'(exp_q3.size()), 64'd0);
        chk("q0_empty", 64'(exp_q0.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
